lcd_bar_display: RTL

Parametrised successor to the single-line LCD control FSM. It sits between the MCU-fed SPI receiver and the byte-level LCD writer. After power-up it initialises an HD44780-class character display. On each update it draws a parameter character on line 1 and a COLS-cell bar graph of a VAL_W-bit value on line 2. Compared with the earlier FSM it adds:
- generic column count and value width
- a frame snapshot of the inputs
- an update-pending latch, so an update arriving mid-draw is not lost
- optional half-cell bar resolution

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_bar_display_bar_cell_gen.sv | 48 ++++
 rtl/lcd_bar_display.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared state encoding, HD44780 command bytes and bar glyphs for lcd_bar_display.
// LCD_HALF_BAR_EN adds the CGRAM state that loads the half-block glyph.
package lcd_pkg;

`ifdef LCD_HALF_BAR_EN
  typedef enum logic [2:0] {
    INIT_WAIT, CFG, CGRAM, IDLE, PARAM_POS, PARAM_CHAR, VALUE_POS, VALUE_CELL
  } state_t;
`else
  typedef enum logic [2:0] {
    INIT_WAIT, CFG, IDLE, PARAM_POS, PARAM_CHAR, VALUE_POS, VALUE_CELL
  } state_t;
`endif

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;
  localparam logic [7:0] CGRAM0   = 8'h40;

  localparam logic [7:0] FULL     = 8'hFF;
  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [7:0] HALF     = 8'h00;
  localparam logic [7:0] HALF_ROW = 8'h1C;

  localparam int CGRAM_ROWS = 8;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = FUNC_SET;
      2'd1:    b = ENTRY;
      default: b = DISP_ON;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_bar_display_bar_cell_gen.sv
// Combinational bar-graph glyph for one column of the snapshot value.
// LCD_HALF_BAR_EN selects the half-cell rule; otherwise full cells only.
module bar_cell_gen
  import lcd_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int VAL_W = 8,
  parameter int COL_W = 5
) (
  input  logic [VAL_W-1:0] value_i,
  input  logic [COL_W-1:0] col_i,
  output logic [7:0]       cell_o
);

  // One spare bit above VAL_W + clog2(COLS+1) keeps the doubled half-cell terms exact.
  localparam int PW = VAL_W + $clog2(COLS + 1) + 1;

  logic [PW-1:0] scaled_s;
  logic [PW-1:0] lo_thr_s;
`ifdef LCD_HALF_BAR_EN
  logic [PW-1:0] hi_thr_s;
`endif

  // Compare value*COLS against the column's threshold in units of 2^VAL_W.
  always_comb begin
`ifdef LCD_HALF_BAR_EN
    scaled_s = PW'(value_i) * PW'(2 * COLS);
    lo_thr_s = PW'(col_i) << (VAL_W + 1);
    hi_thr_s = lo_thr_s + (PW'(1'b1) << VAL_W);
    if (scaled_s > hi_thr_s) begin
      cell_o = FULL;
    end else if (scaled_s > lo_thr_s) begin
      cell_o = HALF;
    end else begin
      cell_o = BLANK;
    end
`else
    scaled_s = PW'(value_i) * PW'(COLS);
    lo_thr_s = PW'(col_i) << VAL_W;
    if (scaled_s > lo_thr_s) begin
      cell_o = FULL;
    end else begin
      cell_o = BLANK;
    end
`endif
  end

endmodule

// File: rtl/lcd_bar_display.sv
// Initialises an HD44780-class LCD, then draws a parameter character and a bar graph
// per update. Optional macro LCD_HALF_BAR_EN loads a half-block glyph for half-cell bars.
module lcd_bar_display
  import lcd_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int VAL_W       = 8,
  parameter int INIT_CYCLES = 800
) (
  input  logic             int_osc,
  input  logic             reset,
  input  logic             en,
  input  logic [VAL_W-1:0] value,
  input  logic [7:0]       param,
  input  logic             SPIDone,
  input  logic             dataDone,
  output logic             dataReady,
  output logic             RSin,
  output logic             RWin,
  output logic [7:0]       dataIn,
  output logic             busy
);

  localparam int IDX_W = $clog2(COLS + 9);
  localparam int CNT_W = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES);
  localparam logic [IDX_W-1:0] CFG_LAST  = IDX_W'(2);
  localparam logic [IDX_W-1:0] COL_LAST  = IDX_W'(COLS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
`ifdef LCD_HALF_BAR_EN
  localparam logic [IDX_W-1:0] CG_LAST   = IDX_W'(CGRAM_ROWS);
`endif

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              pending_q;
  logic [VAL_W-1:0]  frame_val_q;
  logic [7:0]        frame_par_q;
  logic              ready_q;
  logic              rs_q;
  logic              rw_q;
  logic [7:0]        data_q;
  logic              busy_q;

  logic [7:0]        byte_d;
  logic              rs_d;
  logic              last_d;
  logic              post_d;
  state_t            nxt_d;
  logic [7:0]        cell_s;

  bar_cell_gen #(
    .COLS  (COLS),
    .VAL_W (VAL_W),
    .COL_W (IDX_W)
  ) u_cell (
    .value_i (frame_val_q),
    .col_i   (idx_q),
    .cell_o  (cell_s)
  );

  // Byte to issue in the current state/index, and where the state goes after its last byte.
  always_comb begin
    byte_d = 8'h00;
    rs_d   = 1'b0;
    last_d = 1'b1;
    post_d = 1'b0;
    nxt_d  = IDLE;
    case (state_q)
      CFG: begin
        byte_d = cfg_byte(idx_q[1:0]);
        last_d = (idx_q == CFG_LAST);
`ifdef LCD_HALF_BAR_EN
        nxt_d  = CGRAM;
`else
        post_d = 1'b1;
`endif
      end
`ifdef LCD_HALF_BAR_EN
      CGRAM: begin
        if (idx_q == IDX_ZERO) begin
          byte_d = CGRAM0;
          rs_d   = 1'b0;
        end else begin
          byte_d = HALF_ROW;
          rs_d   = 1'b1;
        end
        last_d = (idx_q == CG_LAST);
        post_d = 1'b1;
      end
`endif
      PARAM_POS: begin
        byte_d = LINE1;
        nxt_d  = PARAM_CHAR;
      end
      PARAM_CHAR: begin
        byte_d = frame_par_q;
        rs_d   = 1'b1;
        nxt_d  = VALUE_POS;
      end
      VALUE_POS: begin
        byte_d = LINE2;
        nxt_d  = VALUE_CELL;
      end
      VALUE_CELL: begin
        byte_d = cell_s;
        rs_d   = 1'b1;
        last_d = (idx_q == COL_LAST);
        post_d = 1'b1;
      end
      default: begin
        byte_d = 8'h00;
        rs_d   = 1'b0;
      end
    endcase
  end

  // Sequencer: init wait, byte handshakes, frame snapshot and pending-update latch.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      state_q     <= INIT_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      frame_val_q <= '0;
      frame_par_q <= 8'h00;
      ready_q     <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= 8'h00;
      busy_q      <= 1'b0;
    end else if (en) begin
      rw_q <= 1'b0;
      // Snapshot paths below clear this again when they consume the update.
      if (SPIDone) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        INIT_WAIT: begin
          busy_q <= 1'b1;
          if (cnt_q == INIT_LAST) begin
            state_q <= CFG;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IDLE: begin
          if (SPIDone || pending_q) begin
            frame_val_q <= value;
            frame_par_q <= param;
            pending_q   <= 1'b0;
            idx_q       <= '0;
            state_q     <= PARAM_POS;
            busy_q      <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        default: begin
          busy_q <= 1'b1;
          if (!ready_q) begin
            ready_q <= 1'b1;
            data_q  <= byte_d;
            rs_q    <= rs_d;
          end else if (dataDone) begin
            ready_q <= 1'b0;
            if (!last_d) begin
              idx_q <= idx_q + IDX_W'(1);
            end else if (!post_d) begin
              state_q <= nxt_d;
              idx_q   <= '0;
            end else if (SPIDone || pending_q) begin
              // Redraw straight away without passing through IDLE.
              frame_val_q <= value;
              frame_par_q <= param;
              pending_q   <= 1'b0;
              idx_q       <= '0;
              state_q     <= PARAM_POS;
            end else begin
              idx_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
      endcase
    end else begin
      rw_q <= 1'b0;
    end
  end

  assign dataReady = ready_q;
  assign RSin      = rs_q;
  assign RWin      = rw_q;
  assign dataIn    = data_q;
  assign busy      = busy_q;

endmodule
